guess_check_fsm: RTL

Controller placed around the 4-bit guess load register in the encryption game datapath. On an `enter` pulse it drives the register's `load` strobe for one cycle to capture the player's switch value. It then decrypts the captured guess with the XOR key and compares it with the stored code. It reports grant or deny, counts failed attempts, and forces a timed lockout after `MAX_ATTEMPTS` consecutive failures.

---
 rtl/guess_check_fsm.sv | 96 +++++++++
 1 files changed

// File: rtl/guess_check_fsm.sv
// guess_check_fsm: drives the guess register load strobe on enter, checks the
// XOR-decrypted guess against the stored code, and sequences grant/deny/lock
// indications with a shared 8-bit hold counter. Outputs are registered decodes
// of the state, so inputs never reach outputs combinationally.
module guess_check_fsm #(
  parameter int MAX_ATTEMPTS  = 3,
  parameter int RESULT_CYCLES = 4,
  parameter int LOCK_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [3:0] guess,
  input  logic [3:0] stored_code,
  input  logic [3:0] key,
  output logic       guess_load,
  output logic       busy,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic [1:0] attempts
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, GRANT, DENY, LOCK} state_t;

  // Hold counter reload values: the state lasts (value + 1) cycles.
  localparam logic [7:0] RES_LD  = 8'(RESULT_CYCLES - 1);
  localparam logic [7:0] LOCK_LD = 8'(LOCK_CYCLES - 1);
  localparam logic [2:0] MAX_A   = 3'(MAX_ATTEMPTS);

  state_t     state, state_nxt;
  logic [7:0] hold, hold_nxt;
  logic [1:0] att_nxt;
  logic [2:0] att_inc;
  logic       match;

  // Guess is the value captured by the strobe issued in LOAD.
  assign match   = (guess ^ key) == stored_code;
  // One bit wider so attempts+1 compares cleanly against MAX_ATTEMPTS.
  assign att_inc = {1'b0, attempts} + 3'd1;

  // Next-state, hold counter and failed-attempt bookkeeping.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    att_nxt   = attempts;
    case (state)
      IDLE:  if (enter) state_nxt = LOAD;
      LOAD:  state_nxt = CHECK;
      CHECK: begin
        if (match) begin
          state_nxt = GRANT;
          hold_nxt  = RES_LD;
          att_nxt   = 2'd0;
        end else if (att_inc < MAX_A) begin
          state_nxt = DENY;
          hold_nxt  = RES_LD;
          att_nxt   = att_inc[1:0];
        end else begin
          state_nxt = LOCK;
          hold_nxt  = LOCK_LD;
          att_nxt   = 2'd0;
        end
      end
      GRANT, DENY, LOCK: begin
        if (hold == 8'd0) state_nxt = IDLE;
        else              hold_nxt  = hold - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and Moore outputs registered together; reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= 8'd0;
      attempts   <= 2'd0;
      guess_load <= 1'b0;
      busy       <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      attempts   <= att_nxt;
      guess_load <= (state_nxt == LOAD);
      busy       <= (state_nxt != IDLE);
      granted    <= (state_nxt == GRANT);
      denied     <= (state_nxt == DENY);
      locked     <= (state_nxt == LOCK);
    end
  end

endmodule
